// File: rtl/apb_mem_slave_p_if.sv
// APB bus bundle for the memory slave: master drives the request side,
// slave returns PREADY/PRDATA/PSLVERR. PWAIT carries the requested wait count.
interface apb_mem_slave_p_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int WAIT_W = 4
);
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W/8-1:0] PSTRB;
    logic [WAIT_W-1:0]   PWAIT;
    logic                PREADY;
    logic [DATA_W-1:0]   PRDATA;
    logic                PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PWAIT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PWAIT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB slave fronting a single-cycle memory: captures the request in the setup
// cycle, counts out PWAIT access cycles, then fires one registered memory strobe.
module apb_mem_slave_p #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int WAIT_W    = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_mem_slave_p_if.slave    apb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                ce,
    output logic                wren,
    output logic                rden,
    input  logic [DATA_W-1:0]   MEMRDATA
);
    localparam int              STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH  = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t            state;
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              err_q;
    logic              ready_q;
    logic              slverr_q;

    logic              setup;
    logic              go_access;
    logic [ADDR_W-1:0] src_addr;
    logic              src_write;
    logic [DATA_W-1:0] src_wdata;
    logic [STRB_W-1:0] src_strb;
    logic              src_err;

    assign setup = apb.PSEL && !apb.PENABLE;

    // A zero-wait setup enters ACCESS straight from the bus, so the strobe
    // source is the live bus in IDLE and the captured copy otherwise.
    always_comb begin
        src_addr  = addr_q;
        src_write = write_q;
        src_wdata = wdata_q;
        src_strb  = strb_q;
        src_err   = err_q;
        go_access = 1'b0;
        case (state)
            IDLE: begin
                src_addr  = apb.PADDR;
                src_write = apb.PWRITE;
                src_wdata = apb.PWDATA;
                src_strb  = apb.PSTRB;
                src_err   = ({1'b0, apb.PADDR} >= DEPTH);
                go_access = setup && (apb.PWAIT == '0);
            end
            WAIT:    go_access = apb.PSEL && apb.PENABLE && (cnt == WAIT_W'(1));
            default: go_access = 1'b0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            ce        <= 1'b0;
            wren      <= 1'b0;
            rden      <= 1'b0;
            ready_q   <= 1'b0;
            slverr_q  <= 1'b0;
        end else begin
            ce       <= 1'b0;
            wren     <= 1'b0;
            rden     <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                        strb_q  <= apb.PSTRB;
                        err_q   <= src_err;
                        cnt     <= apb.PWAIT;
                        state   <= (apb.PWAIT == '0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else if (apb.PENABLE) begin
                        cnt <= cnt - WAIT_W'(1);
                        if (cnt == WAIT_W'(1))
                            state <= ACCESS;
                    end
                end
                ACCESS:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Outputs for the ACCESS cycle are registered on the way in.
            if (go_access) begin
                ready_q   <= 1'b1;
                slverr_q  <= src_err;
                wren      <= !src_err && src_write && (src_strb != '0);
                rden      <= !src_err && !src_write;
                ce        <= !src_err && (!src_write || (src_strb != '0));
                mem_addr  <= src_addr;
                mem_wdata <= src_wdata;
                mem_be    <= src_write ? src_strb : '0;
            end
        end
    end

    assign apb.PREADY  = ready_q;
    assign apb.PSLVERR = slverr_q;
    assign apb.PRDATA  = rden ? MEMRDATA : '0;
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Scoreboard bench: the driver predicts each transfer's outcome from a word-array
// model; a negedge monitor pops and compares whenever PREADY is seen.
module tb_apb_mem_slave_p;
    localparam int ADDR_W = 8, DATA_W = 32, WAIT_W = 4, DEPTH = 128;

    typedef struct {
        int          ready_cyc;
        bit          err, ce, wren, rden;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    logic        PCLK = 0;
    logic        PRESETn = 1;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, memrdata;
    logic [3:0]  mem_be;
    logic        ce, wren, rden;
    int          cyc = 0;
    int          tests = 0, fails = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] dut_mem [256];
    exp_t        sb [$];
    exp_t        mon_e;

    apb_mem_slave_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W)) bus ();

    apb_mem_slave_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W), .MEM_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .ce(ce), .wren(wren), .rden(rden), .MEMRDATA(memrdata)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // The memory the DUT actually talks to.
    assign memrdata = dut_mem[mem_addr];
    always @(posedge PCLK)
        if (wren)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) dut_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge PCLK) begin
        if (bus.PREADY) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(mon_e.ready_cyc));
                chk("pslverr", 32'(bus.PSLVERR), 32'(mon_e.err));
                chk("ce",      32'(ce),   32'(mon_e.ce));
                chk("wren",    32'(wren), 32'(mon_e.wren));
                chk("rden",    32'(rden), 32'(mon_e.rden));
                chk("prdata",  bus.PRDATA, mon_e.rdata);
                if (mon_e.ce)   chk("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
                if (mon_e.wren) begin
                    chk("mem_wdata", mem_wdata, mon_e.wdata);
                    chk("mem_be", 32'(mem_be), 32'(mon_e.be));
                end
            end
        end else begin
            chk("idle_outputs", {27'd0, ce, wren, rden, bus.PSLVERR, |bus.PRDATA}, 32'd0);
        end
    end

    task automatic check_reset_outputs();
        chk("rst_pready", 32'(bus.PREADY), 0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 0);
        chk("rst_strobes", {29'd0, ce, wren, rden}, 0);
        chk("rst_prdata", bus.PRDATA, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    task automatic setup_bus(input bit wr, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] w);
        @(posedge PCLK); #1;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr;
        bus.PADDR = a; bus.PWDATA = d; bus.PSTRB = s; bus.PWAIT = w;
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] w, input int stall, output int done);
        exp_t e;
        int   n;
        setup_bus(wr, a, d, s, w);
        e.ready_cyc = cyc + 1 + int'(w) + ((w != 0) ? stall : 0);
        e.err   = (a >= DEPTH);
        e.wren  = wr && !e.err && (s != 0);
        e.rden  = !wr && !e.err;
        e.ce    = e.wren || e.rden;
        e.addr  = a; e.wdata = d; e.be = s;
        e.rdata = e.rden ? ref_mem[a] : 32'd0;
        if (e.wren)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        sb.push_back(e);
        @(posedge PCLK); #1;
        if (w != 0) repeat (stall) begin @(posedge PCLK); #1; end
        bus.PENABLE = 1;
        for (n = 0; n < 40; n++) begin
            @(negedge PCLK);
            if (bus.PREADY) break;
        end
        if (n == 40) chk("ready_timeout", 32'd0, 32'd1);
        done = cyc;
    endtask

    // Abandon a transfer after k access cycles (k < w, so it never reaches ACCESS).
    task automatic xfer_abort(input bit wr, input logic [7:0] a, input logic [3:0] w, input int k);
        setup_bus(wr, a, 32'hA5A5_0000 | 32'(a), 4'hF, w);
        @(posedge PCLK); #1;
        bus.PENABLE = 1;
        repeat (k - 1) begin @(posedge PCLK); #1; end
        @(posedge PCLK); #1;
        bus.PSEL = 0; bus.PENABLE = 0;
        repeat (3) @(posedge PCLK);
    endtask

    initial begin
        int done, prev;
        bit wr;
        logic [7:0] a;
        logic [3:0] w;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
            dut_mem[i] = ref_mem[i];
        end
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        bus.PADDR = 0; bus.PWDATA = 0; bus.PSTRB = 0; bus.PWAIT = 0;
        #1 PRESETn = 0;
        #1 check_reset_outputs();
        repeat (2) @(negedge PCLK);
        PRESETn = 1;

        xfer(1, 8'h10, 32'hDEAD_BEEF, 4'hF, 4'd0, 0, done);
        xfer(0, 8'h10, 32'h0, 4'h0, 4'd3, 0, done);
        xfer(1, 8'hFF, 32'h1234_5678, 4'hF, 4'd0, 0, done);
        xfer(0, 8'd128, 32'h0, 4'h0, 4'd1, 0, done);
        xfer(1, 8'd127, 32'hCAFE_F00D, 4'h5, 4'd2, 0, done);
        xfer(0, 8'd127, 32'h0, 4'h0, 4'd0, 0, done);
        idle();
        xfer_abort(1, 8'h20, 4'd5, 2);

        xfer(1, 8'h01, 32'h1111_1111, 4'h3, 4'd0, 0, prev);
        for (int i = 2; i <= 4; i++) begin
            xfer(1, 8'(i), 32'h1111_1111 * 32'(i), 4'h3, 4'd0, 0, done);
            chk("b2b_spacing", 32'(done - prev), 32'd2);
            prev = done;
        end
        xfer(1, 8'h05, 32'h5555_5555, 4'h0, 4'd0, 0, done);
        chk("b2b_spacing", 32'(done - prev), 32'd2);
        for (int i = 1; i <= 5; i++) xfer(0, 8'(i), 32'h0, 4'h0, 4'd0, 0, done);
        idle();

        // Reset in the middle of a PWAIT=4 write, after a transfer left mem_* nonzero.
        xfer(1, 8'h33, 32'h0BAD_CAFE, 4'hF, 4'd0, 0, done);
        setup_bus(1, 8'h40, 32'hFFFF_FFFF, 4'hF, 4'd4);
        @(posedge PCLK); #1;
        bus.PENABLE = 1;
        @(posedge PCLK);
        @(posedge PCLK); #3;
        PRESETn = 0;
        #1 check_reset_outputs();
        bus.PSEL = 0; bus.PENABLE = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        xfer(0, 8'h40, 32'h0, 4'h0, 4'd0, 0, done);
        xfer(0, 8'h33, 32'h0, 4'h0, 4'd0, 0, done);

        for (int i = 0; i < 120; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
            w  = 4'($urandom_range(0, 3));
            if (w >= 2 && $urandom_range(0, 5) == 0)
                xfer_abort(wr, a, w, int'($urandom_range(1, int'(w) - 1)));
            else
                xfer(wr, a, $urandom, 4'($urandom_range(0, 15)), w, int'($urandom_range(0, 2)), done);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (4) @(posedge PCLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
